// File: rtl/bw_io_cmos2_od_xmit.sv
// Open-drain bit-serial transmitter for a pulled-up CMOS2 pad.
// Drives the pad low for 0 bits, releases it for 1 bits, and reads the pad back to detect collisions.
module bw_io_cmos2_od_xmit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst_l,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] tx_data,
    input  logic [7:0]       div,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             collision,
    output logic             pad_oe,
    output logic             pad_data,
    input  logic             pad_to_core
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PER_W = 9;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_HI = 2'd1,
        S_BIT     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [WIDTH-1:0] r_rx, w_rx_nxt;
    logic [CNT_W-1:0] r_bit, w_bit_nxt;
    logic [PER_W-1:0] r_period, w_period_nxt;
    logic [PER_W-1:0] r_phase, w_phase_nxt;
    logic             r_coll, w_coll_nxt;
    logic             r_oe, w_oe_nxt;
    logic             r_busy, r_done;
    logic             r_sync1, r_psync;

    assign busy      = r_busy;
    assign done      = r_done;
    assign rx_data   = r_rx;
    assign collision = r_coll;
    assign pad_oe    = r_oe;
    assign pad_data  = 1'b0;

    // Two-flop synchronizer; resets high to match an idle pulled-up pad
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_sync1 <= 1'b1;
            r_psync <= 1'b1;
        end else begin
            r_sync1 <= pad_to_core;
            r_psync <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_rx     <= '0;
            r_bit    <= '0;
            r_period <= '0;
            r_phase  <= '0;
            r_coll   <= 1'b0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_rx     <= w_rx_nxt;
            r_bit    <= w_bit_nxt;
            r_period <= w_period_nxt;
            r_phase  <= w_phase_nxt;
            r_coll   <= w_coll_nxt;
            r_oe     <= w_oe_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_rx_nxt     = r_rx;
        w_bit_nxt    = r_bit;
        w_period_nxt = r_period;
        w_phase_nxt  = r_phase;
        w_coll_nxt   = r_coll;
        w_oe_nxt     = r_oe;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_oe_nxt = 1'b0;
                    if (start) begin
                        w_shift_nxt  = tx_data;
                        w_period_nxt = (div < 8'd3) ? PER_W'(4) : PER_W'(div) + PER_W'(1);
                        w_coll_nxt   = 1'b0;
                        w_rx_nxt     = '0;
                        w_state_nxt  = S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    w_oe_nxt = 1'b0;
                    if (r_psync) begin
                        w_state_nxt = S_BIT;
                        w_bit_nxt   = '0;
                        w_phase_nxt = '0;
                        w_oe_nxt    = ~r_shift[WIDTH-1];
                    end
                end
                S_BIT: begin
                    w_phase_nxt = r_phase + PER_W'(1);
                    if (r_phase == r_period - PER_W'(1)) begin
                        // A released bit reading low means another driver owns the wire
                        if (!r_oe && !r_psync) begin
                            w_coll_nxt  = 1'b1;
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_rx_nxt = {r_rx[WIDTH-2:0], r_psync};
                            if (r_bit == CNT_W'(WIDTH - 1)) begin
                                w_oe_nxt    = 1'b0;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_bit_nxt   = r_bit + CNT_W'(1);
                                w_phase_nxt = '0;
                                w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                                w_oe_nxt    = ~r_shift[WIDTH-2];
                            end
                        end
                    end
                end
                S_DONE: begin
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bw_io_cmos2_od_xmit.sv
// Directed bench for bw_io_cmos2_od_xmit with a pulled-up pad model and an external pull-down.
module tb_bw_io_cmos2_od_xmit;

    logic       clk = 1'b0;
    logic       arst_l;
    logic       start;
    logic       abort;
    logic [7:0] tx_data;
    logic [7:0] div;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       collision;
    logic       pad_oe;
    logic       pad_data;
    logic       ext_low;
    logic       pad;

    int n_cmp  = 0;
    int n_fail = 0;

    // Pad resolves high unless our driver or an external device pulls it low
    assign pad = ~pad_oe & ~ext_low;

    always #5 clk = ~clk;

    bw_io_cmos2_od_xmit #(.WIDTH(8)) dut (
        .clk        (clk),
        .arst_l     (arst_l),
        .start      (start),
        .abort      (abort),
        .tx_data    (tx_data),
        .div        (div),
        .busy       (busy),
        .done       (done),
        .rx_data    (rx_data),
        .collision  (collision),
        .pad_oe     (pad_oe),
        .pad_data   (pad_data),
        .pad_to_core(pad)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, ".pad_oe"}, 32'(pad_oe), 32'd0);
        chk({tag, ".pad_data"}, 32'(pad_data), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".collision"}, 32'(collision), 32'd0);
        chk({tag, ".rx_data"}, 32'(rx_data), 32'd0);
    endtask

    logic [7:0] exp_oe;
    bit         seen;

    initial begin
        arst_l  = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        tx_data = 8'h00;
        div     = 8'd0;
        ext_low = 1'b0;
        #1;
        chk_idle_reset("por");
        step(3);
        arst_l = 1'b1;
        step(2);

        // Normal frame A5, div=3 -> P=4
        tx_data = 8'hA5; div = 8'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("a5.busy_after_start", 32'(busy), 32'd1);
        chk("a5.oe_wait_hi", 32'(pad_oe), 32'd0);
        step(1);
        exp_oe = 8'b0101_1010;
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("a5.oe_bit%0d_c%0d", b, c), 32'(pad_oe), 32'(exp_oe[7-b]));
                chk($sformatf("a5.nodone_bit%0d_c%0d", b, c), 32'(done), 32'd0);
                step(1);
            end
        end
        chk("a5.done", 32'(done), 32'd1);
        chk("a5.rx", 32'(rx_data), 32'hA5);
        chk("a5.coll", 32'(collision), 32'd0);
        chk("a5.oe_done", 32'(pad_oe), 32'd0);
        step(1);
        chk("a5.done_clear", 32'(done), 32'd0);
        chk("a5.busy_clear", 32'(busy), 32'd0);
        chk("a5.rx_held", 32'(rx_data), 32'hA5);

        // Collision on bit 3, FF, div=7 -> P=8
        step(1);
        tx_data = 8'hFF; div = 8'd7; start = 1'b1;
        step(1);
        start = 1'b0;
        step(25);
        ext_low = 1'b1;
        step(7);
        chk("coll.pre_done", 32'(done), 32'd0);
        chk("coll.pre_flag", 32'(collision), 32'd0);
        step(1);
        chk("coll.done", 32'(done), 32'd1);
        chk("coll.flag", 32'(collision), 32'd1);
        chk("coll.oe", 32'(pad_oe), 32'd0);
        chk("coll.rx", 32'(rx_data), 32'h07);
        step(1);
        ext_low = 1'b0;
        chk("coll.done_clear", 32'(done), 32'd0);
        chk("coll.busy_clear", 32'(busy), 32'd0);
        chk("coll.sticky", 32'(collision), 32'd1);
        step(3);

        // Async reset mid-frame
        tx_data = 8'h00; div = 8'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        chk("rst.oe_driving", 32'(pad_oe), 32'd1);
        #3;
        arst_l = 1'b0;
        #1;
        chk_idle_reset("rst");
        #2;
        arst_l = 1'b1;
        step(2);
        tx_data = 8'h00; div = 8'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("rst.restart_busy", 32'(busy), 32'd1);
        chk("rst.restart_wait_hi", 32'(pad_oe), 32'd0);
        step(1);
        chk("rst.restart_bit0", 32'(pad_oe), 32'd1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        step(2);

        // WAIT_HI: pad held low externally before and after start
        ext_low = 1'b1;
        step(3);
        tx_data = 8'h5A; div = 8'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("wait.oe_%0d", i), 32'(pad_oe), 32'd0);
            chk($sformatf("wait.busy_%0d", i), 32'(busy), 32'd1);
            step(1);
        end
        ext_low = 1'b0;
        step(2);
        chk("wait.oe_sync", 32'(pad_oe), 32'd0);
        step(1);
        chk("wait.oe_bit0", 32'(pad_oe), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(1);
            if (done) seen = 1'b1;
        end
        chk("wait.done_seen", 32'(seen), 32'd1);
        chk("wait.rx", 32'(rx_data), 32'h5A);
        step(2);

        // div=0 clamps to P=4; all-zero frame drives the pad for 32 cycles
        tx_data = 8'h00; div = 8'd0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("div0.oe_%0d", i), 32'(pad_oe), 32'd1);
            step(1);
        end
        chk("div0.done", 32'(done), 32'd1);
        chk("div0.oe_release", 32'(pad_oe), 32'd0);
        chk("div0.rx", 32'(rx_data), 32'h00);
        chk("div0.coll", 32'(collision), 32'd0);
        step(2);

        // Start pulsed mid-frame is ignored
        tx_data = 8'hA5; div = 8'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        step(6);
        tx_data = 8'h00; start = 1'b1;
        step(1);
        start = 1'b0;
        step(24);
        chk("ign.pre_done", 32'(done), 32'd0);
        step(2);
        chk("ign.done", 32'(done), 32'd1);
        chk("ign.rx", 32'(rx_data), 32'hA5);
        step(2);

        // Abort during bit 5 of F8 (bit 5 drives low)
        tx_data = 8'hF8; div = 8'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        step(22);
        chk("abort.oe_bit5", 32'(pad_oe), 32'd1);
        chk("abort.busy_bit5", 32'(busy), 32'd1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort.oe", 32'(pad_oe), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.rx_kept", 32'(rx_data), 32'h1F);
        chk("abort.coll_kept", 32'(collision), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("abort.nodone_%0d", i), 32'(done), 32'd0);
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
